psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the systolic core; consumes the output-FIFO vectors produced by each kernel-index (kij) pass.
- Accumulates the vectors into the psum SRAM with a read-modify-write per output row.
- On the final pass, optionally applies ReLU before the write.
- Signals pass and convolution completion to the controller.

Parameters:
- col, 8, number of output lanes per vector
- psum_bw, 16, signed psum width per lane
- num_inp, 64, output rows (vectors) per kij pass
- kij_len, 9, number of kij passes per convolution
- addr_bw, 11, psum SRAM address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a new convolution (all kij passes); sampled only in IDLE
- relu_en  in  1  apply ReLU to the final-pass write data
- ofifo_valid  in  1  OFIFO holds at least one vector
- ofifo_rd  out  1  pop strobe; data is valid on ofifo_dout in the same cycle
- ofifo_dout  in  col*psum_bw  popped vector; lane k is bits [k*psum_bw +: psum_bw]
- mem_cen  out  1  psum SRAM chip enable, active-low
- mem_wen  out  1  psum SRAM write enable, active-low
- mem_addr  out  addr_bw  psum SRAM address
- mem_din  out  col*psum_bw  psum SRAM write data
- mem_dout  in  col*psum_bw  psum SRAM read data, valid 1 cycle after a read
- kij_cnt  out  4  current pass index
- iter_done  out  1  single-cycle pulse at the end of each pass
- compute_done  out  1  level, high after the last pass until the next start

Behaviour:
- Reset values while reset is low: state IDLE; addr/kij_cnt/all outputs 0; mem_cen=1, mem_wen=1; psum SRAM contents untouched.
- Reset mid-operation aborts the pass and returns to IDLE. Any partially popped OFIFO data is discarded.
- IDLE:
  - start=1 -> clear row and kij_cnt, clear compute_done, go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - ofifo_valid=0 -> stall with ofifo_rd=0 and mem_cen=1.
  - ofifo_valid=1 -> ofifo_rd=1 and ofifo_dout latched into a data register.
  - kij_cnt==0: go to WRITE with addend=0; no SRAM read is issued.
  - kij_cnt>0: mem_cen=0, mem_wen=1, mem_addr=row; go to WRITE.
- WRITE (one cycle):
  - Per-lane sum = latched lane + (kij_cnt==0 ? 0 : mem_dout lane).
  - Sum is signed, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If relu_en and kij_cnt==kij_len-1, negative lanes are forced to 0.
  - mem_cen=0, mem_wen=0, mem_addr=row, mem_din=result.
  - row<num_inp-1 -> row++, go to FETCH.
  - Otherwise go to PASS_END.
- PASS_END (one cycle):
  - iter_done=1 and row reset to 0.
  - kij_cnt<kij_len-1 -> kij_cnt++, go to FETCH.
  - Otherwise compute_done=1, go to IDLE.
- Throughput is one vector per 2 cycles. Minimum pass latency is 2*num_inp+1 cycles.
- An ofifo_valid drop between rows only stalls FETCH; the WRITE state is never stalled.
- SRAM reads and writes never occur in the same cycle, so a single-port SRAM is sufficient.
- mem_cen=1 in all cycles not listed above.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, WRITE, PASS_END)
  - psum_bw-wide saturation limit constants
  - lane-slice helper function
- Sub-module psum_lane_add: one lane of saturating add plus ReLU, instantiated col times.

Test Plan:
- kij_len=1, 4 vectors with all lanes equal to 5: SRAM rows 0..3 hold 5 in all lanes. No SRAM read is ever issued (mem_cen stays high in FETCH). One iter_done pulse, then compute_done=1.
- kij_len=3, every vector lane=2, relu_en=0: each row holds 6. iter_done pulses 3 times, 2*num_inp+1 cycles apart when the OFIFO is always valid.
- Saturation: lane pushes of 32000 then 1000 -> row value 32767. Pushes of -32000 then -1000 -> -32768.
- ReLU: pushes of -3 then -4 with relu_en=1 -> 0 written on the final pass. The same stimulus with relu_en=0 -> -7.
- OFIFO starvation: ofifo_valid low for 10 cycles at row 5 -> no ofifo_rd, no SRAM access in that window, and the final results are identical to the unstalled run.
- Reset mid-pass at kij_cnt=1, row 20: outputs return to reset values asynchronously. A new start restarts at kij_cnt=0, and rows 0..num_inp-1 are fully overwritten.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the psum accumulator: FSM states, default
// geometry, saturation limits and a lane-slice helper.
package psum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        PASS_END
    } state_t;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned NUM_INP = 64;
    localparam int unsigned KIJ_LEN = 9;
    localparam int unsigned ADDR_BW = 11;

    typedef logic signed [PSUM_BW-1:0]  psum_t;
    typedef logic [COL*PSUM_BW-1:0]     psum_vec_t;

    localparam psum_t PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam psum_t PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    function automatic psum_t lane_slice(input psum_vec_t vec, input int unsigned k);
        return vec[k*PSUM_BW +: PSUM_BW];
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// OFIFO pop interface and psum SRAM port bundled together; the accumulator
// is the master, the FIFO/SRAM side is the slave.
interface psum_accumulator_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned addr_bw = 11
);
    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   ofifo_dout;
    logic                     mem_cen;
    logic                     mem_wen;
    logic [addr_bw-1:0]       mem_addr;
    logic [col*psum_bw-1:0]   mem_din;
    logic [col*psum_bw-1:0]   mem_dout;

    modport master (
        input  ofifo_valid,
        input  ofifo_dout,
        input  mem_dout,
        output ofifo_rd,
        output mem_cen,
        output mem_wen,
        output mem_addr,
        output mem_din
    );

    modport slave (
        output ofifo_valid,
        output ofifo_dout,
        output mem_dout,
        input  ofifo_rd,
        input  mem_cen,
        input  mem_wen,
        input  mem_addr,
        input  mem_din
    );
endinterface

// File: rtl/psum_accumulator_lane_add.sv
// One output lane: signed saturating add of two psum values, with optional
// ReLU clamp of the saturated result.
module psum_lane_add
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW
) (
    input  logic signed [psum_bw-1:0] a,
    input  logic signed [psum_bw-1:0] b,
    input  logic                      relu,
    output logic signed [psum_bw-1:0] result
);
    localparam logic signed [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic signed [psum_bw:0]   sum_wide;
    logic signed [psum_bw-1:0] sat;

    assign sum_wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};

    // Overflow shows as disagreement between the extra sign bit and the MSB.
    always_comb begin
        sat = sum_wide[psum_bw-1:0];
        if (sum_wide[psum_bw] != sum_wide[psum_bw-1]) begin
            sat = sum_wide[psum_bw] ? LANE_MIN : LANE_MAX;
        end
        result = (relu && sat[psum_bw-1]) ? '0 : sat;
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates OFIFO vectors from each kij pass into the psum SRAM with a
// read-modify-write per row; optional ReLU on the final pass.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned num_inp = NUM_INP,
    parameter int unsigned kij_len = KIJ_LEN,
    parameter int unsigned addr_bw = ADDR_BW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                relu_en,
    psum_accumulator_if.master  bus,
    output logic [3:0]          kij_cnt,
    output logic                iter_done,
    output logic                compute_done
);
    localparam logic [3:0]         KIJ_LAST = 4'(kij_len - 1);
    localparam logic [addr_bw-1:0] ROW_LAST = addr_bw'(num_inp - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [addr_bw-1:0]     row;
    logic [col*psum_bw-1:0] data_q;
    logic [col*psum_bw-1:0] result;
    logic                   first_pass;
    logic                   last_pass;
    logic                   last_row;
    logic                   relu_apply;

    assign first_pass = (kij_cnt == '0);
    assign last_pass  = (kij_cnt == KIJ_LAST);
    assign last_row   = (row == ROW_LAST);
    assign relu_apply = relu_en && last_pass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row          <= '0;
            kij_cnt      <= '0;
            data_q       <= '0;
            compute_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row          <= '0;
                        kij_cnt      <= '0;
                        compute_done <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.ofifo_valid) begin
                        data_q <= bus.ofifo_dout;
                    end
                end
                WRITE: begin
                    if (!last_row) begin
                        row <= row + addr_bw'(1);
                    end
                end
                PASS_END: begin
                    row <= '0;
                    if (!last_pass) begin
                        kij_cnt <= kij_cnt + 4'd1;
                    end else begin
                        compute_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read is issued in FETCH so mem_dout lands in WRITE; the SRAM port is
    // never read and written in the same cycle.
    always_comb begin
        state_nxt    = state;
        bus.ofifo_rd = 1'b0;
        bus.mem_cen  = 1'b1;
        bus.mem_wen  = 1'b1;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        iter_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (bus.ofifo_valid) begin
                    bus.ofifo_rd = 1'b1;
                    if (!first_pass) begin
                        bus.mem_cen  = 1'b0;
                        bus.mem_addr = row;
                    end
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.mem_cen  = 1'b0;
                bus.mem_wen  = 1'b0;
                bus.mem_addr = row;
                bus.mem_din  = result;
                state_nxt    = last_row ? PASS_END : FETCH;
            end
            PASS_END: begin
                iter_done = 1'b1;
                state_nxt = last_pass ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < col; k++) begin : g_lane
        logic signed [psum_bw-1:0] addend;
        assign addend = first_pass ? '0 : bus.mem_dout[k*psum_bw +: psum_bw];

        psum_lane_add #(
            .psum_bw (psum_bw)
        ) u_lane (
            .a      (data_q[k*psum_bw +: psum_bw]),
            .b      (addend),
            .relu   (relu_apply),
            .result (result[k*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a kij_len=1 instance and a kij_len=3
// instance, each with its own OFIFO feed and SRAM model.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    localparam int NUM_A = 4;
    localparam int NUM_B = 32;
    localparam int KIJ_B = 3;
    localparam int FEED_B = NUM_B * KIJ_B;

    typedef struct {
        int p0;
        int p1;
        int p2;
        int rm;
        int e_lin;
        int e_relu;
    } lane_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b, start_a, start_b, relu_b, stall_b, feed_clr_b;
    logic [3:0] kij_a, kij_b;
    logic iter_a, iter_b, cdone_a, cdone_b;

    psum_accumulator_if #(.col(8), .psum_bw(16), .addr_bw(11)) bus_a ();
    psum_accumulator_if #(.col(8), .psum_bw(16), .addr_bw(11)) bus_b ();

    psum_accumulator #(.col(8), .psum_bw(16), .num_inp(NUM_A), .kij_len(1), .addr_bw(11)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .relu_en(1'b0), .bus(bus_a),
        .kij_cnt(kij_a), .iter_done(iter_a), .compute_done(cdone_a));

    psum_accumulator #(.col(8), .psum_bw(16), .num_inp(NUM_B), .kij_len(KIJ_B), .addr_bw(11)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .relu_en(relu_b), .bus(bus_b),
        .kij_cnt(kij_b), .iter_done(iter_b), .compute_done(cdone_b));

    logic [127:0] feed_a [NUM_A];
    logic [127:0] feed_b [FEED_B];
    int idx_a, idx_b;

    assign bus_a.ofifo_valid = (idx_a < NUM_A);
    assign bus_a.ofifo_dout  = feed_a[(idx_a < NUM_A) ? idx_a : 0];
    assign bus_b.ofifo_valid = (idx_b < FEED_B) && !stall_b;
    assign bus_b.ofifo_dout  = feed_b[(idx_b < FEED_B) ? idx_b : 0];

    always @(posedge clk or negedge reset_a)
        if (!reset_a) idx_a <= 0;
        else if (bus_a.ofifo_rd) idx_a <= idx_a + 1;

    always @(posedge clk or negedge reset_b)
        if (!reset_b) idx_b <= 0;
        else if (feed_clr_b) idx_b <= 0;
        else if (bus_b.ofifo_rd) idx_b <= idx_b + 1;

    logic [127:0] sram_a [2048];
    logic [127:0] sram_b [2048];

    always @(posedge clk) begin
        if (!bus_a.mem_cen) begin
            if (!bus_a.mem_wen) sram_a[bus_a.mem_addr] <= bus_a.mem_din;
            else                bus_a.mem_dout <= sram_a[bus_a.mem_addr];
        end
        if (!bus_b.mem_cen) begin
            if (!bus_b.mem_wen) sram_b[bus_b.mem_addr] <= bus_b.mem_din;
            else                bus_b.mem_dout <= sram_b[bus_b.mem_addr];
        end
    end

    int cyc = 0;
    int reads_a = 0;
    int n_iter_a = 0;
    int n_iter_b = 0;
    int iter_t [64];

    always @(negedge clk) begin
        cyc++;
        if (!bus_a.mem_cen && bus_a.mem_wen) reads_a++;
        if (iter_a) n_iter_a++;
        if (iter_b) begin
            if (n_iter_b < 64) iter_t[n_iter_b] = cyc;
            n_iter_b++;
        end
    end

    int tests = 0;
    int fails = 0;
    lane_vec_t tab [8];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_row(input int r, input bit relu);
        logic [127:0] v;
        for (int k = 0; k < 8; k++)
            v[k*16 +: 16] = 16'((relu ? tab[k].e_relu : tab[k].e_lin) + 3 * tab[k].rm * r);
        return v;
    endfunction

    task automatic check_rows_b(input string tag, input bit relu);
        for (int r = 0; r < NUM_B; r++)
            check($sformatf("%s_row%0d", tag, r), 256'(sram_b[r]), 256'(exp_row(r, relu)));
    endtask

    task automatic check_reset_b(input string name);
        check(name, 256'({bus_b.ofifo_rd, bus_b.mem_cen, bus_b.mem_wen, bus_b.mem_addr,
                          bus_b.mem_din, kij_b, iter_b, cdone_b}),
              256'({1'b0, 1'b1, 1'b1, 11'd0, 128'd0, 4'd0, 1'b0, 1'b0}));
    endtask

    task automatic run_b(input string tag, input bit relu, input bit stray_start);
        int i;
        @(negedge clk);
        relu_b = relu;
        feed_clr_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        feed_clr_b = 1'b0;
        start_b = 1'b0;
        check({tag, "_cdone_cleared"}, 256'(cdone_b), 256'(0));
        for (i = 0; i < 500 && !cdone_b; i++) begin
            @(negedge clk);
            if (stray_start) start_b = (i == 30);
        end
        start_b = 1'b0;
        check({tag, "_cdone"}, 256'(cdone_b), 256'(1));
    endtask

    initial begin
        int n0;
        int i;
        logic [127:0] five;

        tab[0] = '{2, 2, 2, 0, 6, 6};
        tab[1] = '{32000, 1000, 0, 0, int'(PSUM_MAX), int'(PSUM_MAX)};
        tab[2] = '{-32000, -1000, 0, 0, int'(PSUM_MIN), 0};
        tab[3] = '{-3, -4, 0, 0, -7, 0};
        tab[4] = '{0, 0, 0, 1, 0, 0};
        tab[5] = '{100, -50, -60, 0, -10, 0};
        tab[6] = '{32767, 32767, -32768, 0, -1, 0};
        tab[7] = '{-5, 10, 3, 0, 8, 8};

        for (int k = 0; k < 8; k++) five[k*16 +: 16] = 16'd5;
        for (int r = 0; r < NUM_A; r++) feed_a[r] = five;
        for (int p = 0; p < KIJ_B; p++)
            for (int r = 0; r < NUM_B; r++)
                for (int k = 0; k < 8; k++)
                    feed_b[p*NUM_B + r][k*16 +: 16] =
                        16'(((p == 0) ? tab[k].p0 : (p == 1) ? tab[k].p1 : tab[k].p2) + tab[k].rm * r);

        reset_a = 1'b0; reset_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        relu_b = 1'b0; stall_b = 1'b0; feed_clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", 256'({bus_a.ofifo_rd, bus_a.mem_cen, bus_a.mem_wen, bus_a.mem_addr,
                              bus_a.mem_din, kij_a, iter_a, cdone_a}),
              256'({1'b0, 1'b1, 1'b1, 11'd0, 128'd0, 4'd0, 1'b0, 1'b0}));
        check_reset_b("reset_b");
        reset_a = 1'b1; reset_b = 1'b1;

        // kij_len=1: single pass, no SRAM reads
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (i = 0; i < 100 && !cdone_a; i++) @(negedge clk);
        check("a_cdone", 256'(cdone_a), 256'(1));
        check("a_no_reads", 256'(reads_a), 256'(0));
        check("a_iter_count", 256'(n_iter_a), 256'(1));
        for (int r = 0; r < NUM_A; r++)
            check($sformatf("a_row%0d", r), 256'(sram_a[r]), 256'(five));

        // kij_len=3, no stall, stray start mid-run must be ignored
        n0 = n_iter_b;
        run_b("b1", 1'b0, 1'b1);
        check("b1_iter_count", 256'(n_iter_b - n0), 256'(3));
        check("b1_iter_gap0", 256'(iter_t[n0+1] - iter_t[n0]), 256'(2*NUM_B + 1));
        check("b1_iter_gap1", 256'(iter_t[n0+2] - iter_t[n0+1]), 256'(2*NUM_B + 1));
        check_rows_b("b1", 1'b0);

        // ReLU on final pass
        run_b("b2", 1'b1, 1'b0);
        check_rows_b("b2", 1'b1);

        // OFIFO starvation at pass 1 row 5
        fork
            run_b("b3", 1'b0, 1'b0);
            begin
                for (i = 0; i < 500 && idx_b != NUM_B + 5; i++) @(negedge clk);
                check("b3_stall_reach", 256'(idx_b), 256'(NUM_B + 5));
                stall_b = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    check("b3_stall_quiet", 256'({bus_b.ofifo_rd, bus_b.mem_cen}), 256'(2'b01));
                end
                stall_b = 1'b0;
            end
        join
        check_rows_b("b3", 1'b0);

        // Reset mid-pass at kij_cnt=1 row 20, then full restart with ReLU
        @(negedge clk);
        relu_b = 1'b1;
        feed_clr_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        feed_clr_b = 1'b0;
        start_b = 1'b0;
        for (i = 0; i < 500 && !(kij_b == 4'd1 && bus_b.mem_addr == 11'd20); i++) @(negedge clk);
        check("b4_reach_row20", 256'({kij_b, bus_b.mem_addr}), 256'({4'd1, 11'd20}));
        #2 reset_b = 1'b0;
        #1 check_reset_b("b4_async_reset");
        @(negedge clk);
        reset_b = 1'b1;
        n0 = n_iter_b;
        run_b("b4", 1'b1, 1'b0);
        check("b4_iter_count", 256'(n_iter_b - n0), 256'(3));
        check_rows_b("b4", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
